// File: rtl/video_timing_pkg.sv
// Shared raster timing definitions: totals helper, mode presets and the
// sync-flag bundle carried by the alignment delay line.
package video_timing_pkg;

    // Sync flags travel the delay line in this order, msb first: {hs, vs, de, sof}.
    // Inside the pipeline a 1 always means "asserted"; polarity is applied at the output.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic sof;
    } sync_flags_t;

    localparam int unsigned SYNC_FLAGS_W = $bits(sync_flags_t);

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480@60 (25.175 MHz pixel clock)
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;
    localparam int unsigned VGA640_H_TOTAL  =
        timing_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
    localparam int unsigned VGA640_V_TOTAL  =
        timing_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);

    // 1280x720@60 (74.25 MHz pixel clock)
    localparam int unsigned HD720_H_ACTIVE = 1280;
    localparam int unsigned HD720_H_FP     = 110;
    localparam int unsigned HD720_H_SYNC   = 40;
    localparam int unsigned HD720_H_BP     = 220;
    localparam int unsigned HD720_V_ACTIVE = 720;
    localparam int unsigned HD720_V_FP     = 5;
    localparam int unsigned HD720_V_SYNC   = 5;
    localparam int unsigned HD720_V_BP     = 20;
    localparam int unsigned HD720_H_TOTAL  =
        timing_total(HD720_H_ACTIVE, HD720_H_FP, HD720_H_SYNC, HD720_H_BP);
    localparam int unsigned HD720_V_TOTAL  =
        timing_total(HD720_V_ACTIVE, HD720_V_FP, HD720_V_SYNC, HD720_V_BP);

endpackage

// File: rtl/timing_delay_line.sv
// Clock-enabled shift register used to align control signals with pipelined
// pixel data. DEPTH=0 degenerates to a wire.
module timing_delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, ce_i};
        assign data_o      = data_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per enabled cycle; reset clears every stage.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else if (ce_i) begin
                stage_q[0] <= data_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator. Issues x/y coordinates to upstream
// pixel sources and delays hs/vs/de/sof by PIPE_DELAY enabled cycles so they
// line up with the pixel data returned on pix_i.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int unsigned H_FP       = VGA640_H_FP,
    parameter int unsigned H_SYNC     = VGA640_H_SYNC,
    parameter int unsigned H_BP       = VGA640_H_BP,
    parameter int unsigned V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int unsigned V_FP       = VGA640_V_FP,
    parameter int unsigned V_SYNC     = VGA640_V_SYNC,
    parameter int unsigned V_BP       = VGA640_V_BP,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned PIPE_DELAY = 2,   // 0..15
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned FRAME_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic [3*COLOR_W-1:0] pix_i,
    output logic [CNT_W-1:0]     x_o,
    output logic [CNT_W-1:0]     y_o,
    output logic                 coord_active_o,
    output logic                 hs_o,
    output logic                 vs_o,
    output logic                 de_o,
    output logic                 sof_o,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic [FRAME_W-1:0]   frame_cnt_o
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_STOP    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_STOP    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               line_end;
    logic               frame_end;
    logic               coord_active;

    sync_flags_t             raw_flags;
    sync_flags_t             dly_flags;
    logic [SYNC_FLAGS_W-1:0] raw_vec;
    logic [SYNC_FLAGS_W-1:0] dly_vec;

    // Counter next-state: x wraps at line end, y at frame end, both on one edge.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        frame_d   = frame_q;
        line_end  = (x_q == H_LAST);
        frame_end = line_end && (y_q == V_LAST);
        if (ce_i) begin
            x_d = line_end ? '0 : x_q + CNT_W'(1);
            if (line_end) begin
                y_d = frame_end ? '0 : y_q + CNT_W'(1);
            end
            if (frame_end) begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    assign coord_active = (x_q < H_ACT_END) && (y_q < V_ACT_END);

    // Undelayed sync decode from the current coordinate.
    always_comb begin
        raw_flags     = '0;
        raw_flags.hs  = (x_q >= HS_START) && (x_q < HS_STOP);
        raw_flags.vs  = (y_q >= VS_START) && (y_q < VS_STOP);
        raw_flags.de  = coord_active;
        raw_flags.sof = (x_q == '0) && (y_q == '0);
    end

    assign raw_vec   = raw_flags;
    assign dly_flags = dly_vec;

    timing_delay_line #(
        .WIDTH (SYNC_FLAGS_W),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ce_i   (ce_i),
        .data_i (raw_vec),
        .data_o (dly_vec)
    );

    // Output polarity and blanking; colour is forced to 0 outside de.
    always_comb begin
        hs_o  = dly_flags.hs ? HS_POL : ~HS_POL;
        vs_o  = dly_flags.vs ? VS_POL : ~VS_POL;
        de_o  = dly_flags.de;
        sof_o = dly_flags.sof;
        {red_o, green_o, blue_o} = dly_flags.de ? pix_i : '0;
    end

    assign x_o            = x_q;
    assign y_o            = y_q;
    assign coord_active_o = coord_active;
    assign frame_cnt_o    = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster. Two instances share
// ce/rst: one with PIPE_DELAY=2 and active-low syncs, one with PIPE_DELAY=0 and
// active-high syncs. The reference model derives every output from the count of
// enabled cycles since reset using plain division/modulo.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 1;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;   // 14
    localparam int VT = VA + VF + VSW + VB;   // 7

    typedef struct {
        int x, y, act, hs, vs, de, sof, r, g, b, frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [23:0] pix2, pix0;

    logic [11:0] x2, y2, x0, y0;
    logic        act2, hs2, vs2, de2, sof2, act0, hs0, vs0, de0, sof0;
    logic [7:0]  r2, g2, b2, r0, g0, b0;
    logic [15:0] f2, f0;

    exp_t q2[$];
    exp_t q0[$];
    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;   // enabled cycles since last reset
    bit   known    = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(2)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .pix_i(pix2),
        .x_o(x2), .y_o(y2), .coord_active_o(act2), .hs_o(hs2), .vs_o(vs2),
        .de_o(de2), .sof_o(sof2), .red_o(r2), .green_o(g2), .blue_o(b2),
        .frame_cnt_o(f2)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .pix_i(pix0),
        .x_o(x0), .y_o(y0), .coord_active_o(act0), .hs_o(hs0), .vs_o(vs0),
        .de_o(de0), .sof_o(sof0), .red_o(r0), .green_o(g0), .blue_o(b0),
        .frame_cnt_o(f0)
    );

    // Upstream pixel value for the coordinate issued at enabled cycle m.
    function automatic logic [23:0] pix_of(input int m);
        int px = m % HT;
        int py = (m / HT) % VT;
        return {8'(px ^ 'h5a), 8'(py + 'h11), 8'(px * 3 + py * 7)};
    endfunction

    function automatic exp_t model(input int cnt, input int pd, input bit hpol,
                                   input bit vpol, input logic [23:0] pix);
        exp_t e;
        int   m, mx, my;
        bit   rhs, rvs, rde, rsof;
        e.x     = cnt % HT;
        e.y     = (cnt / HT) % VT;
        e.frame = (cnt / (HT * VT)) % 65536;
        e.act   = int'(e.x < HA && e.y < VA);
        rhs = 0; rvs = 0; rde = 0; rsof = 0;
        if (cnt >= pd) begin
            m    = cnt - pd;
            mx   = m % HT;
            my   = (m / HT) % VT;
            rhs  = (mx >= HA + HF) && (mx < HA + HF + HSW);
            rvs  = (my >= VA + VF) && (my < VA + VF + VSW);
            rde  = (mx < HA) && (my < VA);
            rsof = (mx == 0) && (my == 0);
        end
        e.hs  = int'(rhs ? hpol : !hpol);
        e.vs  = int'(rvs ? vpol : !vpol);
        e.de  = int'(rde);
        e.sof = int'(rsof);
        e.r   = rde ? int'(pix[23:16]) : 0;
        e.g   = rde ? int'(pix[15:8]) : 0;
        e.b   = rde ? int'(pix[7:0]) : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, push expectations for the current
    // state, then advance the model across the coming edge.
    task automatic step(input bit r, input bit c);
        @(negedge clk);
        rst  = r;
        ce   = c;
        pix2 = (n >= 2) ? pix_of(n - 2) : 24'($urandom);
        pix0 = pix_of(n);
        if (known) begin
            q2.push_back(model(n, 2, 1'b0, 1'b0, pix2));
            q0.push_back(model(n, 0, 1'b1, 1'b1, pix0));
        end
        if (r) begin
            n     = 0;
            known = 1'b1;
        end else if (c) begin
            n++;
        end
    endtask

    // Monitor: compare each presented output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("d2.x", 32'(x2), e.x);       chk("d2.y", 32'(y2), e.y);
                chk("d2.act", 32'(act2), e.act); chk("d2.hs", 32'(hs2), e.hs);
                chk("d2.vs", 32'(vs2), e.vs);    chk("d2.de", 32'(de2), e.de);
                chk("d2.sof", 32'(sof2), e.sof); chk("d2.red", 32'(r2), e.r);
                chk("d2.green", 32'(g2), e.g);   chk("d2.blue", 32'(b2), e.b);
                chk("d2.frame", 32'(f2), e.frame);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0.x", 32'(x0), e.x);       chk("d0.y", 32'(y0), e.y);
                chk("d0.act", 32'(act0), e.act); chk("d0.hs", 32'(hs0), e.hs);
                chk("d0.vs", 32'(vs0), e.vs);    chk("d0.de", 32'(de0), e.de);
                chk("d0.sof", 32'(sof0), e.sof); chk("d0.red", 32'(r0), e.r);
                chk("d0.green", 32'(g0), e.g);   chk("d0.blue", 32'(b0), e.b);
                chk("d0.frame", 32'(f0), e.frame);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        ce   = 1'b0;
        pix2 = '0;
        pix0 = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        // Free run, several frames
        repeat (320) step(1'b0, 1'b1);
        // ce pattern 1,0,0,1
        repeat (60) begin
            step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
        end
        // Mid-frame reset at x=5, y=2 (model coordinates)
        for (int i = 0; i < 200; i++) begin
            if ((n % HT) == 5 && ((n / HT) % VT) == 2) break;
            step(1'b0, 1'b1);
        end
        step(1'b1, 1'b1);
        repeat (150) step(1'b0, 1'b1);
        // Random enable with occasional reset
        repeat (1200) step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)));
        repeat (4) step(1'b0, 1'b1);
        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; next generation of the fixed 640x480 VGA sync block.
- Runs on an externally supplied pixel clock, with an optional pixel clock-enable; the clock wizard is not instantiated here.
- Produces pixel coordinates for upstream pixel sources (character ROM, box overlay), then delays sync/DE by a programmable pipeline depth so they line up with upstream pixel data.
- Feeds the HDMI encoder directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 1, asserted level of hs (1 = active-high)
- VS_POL, 1, asserted level of vs
- PIPE_DELAY, 2, pixel-enable cycles between coordinate issue and pix_in return; range 0..15
- CNT_W, 12, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1
- COLOR_W, 8, bits per colour channel
- FRAME_W, 16, frame counter width

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- ce  in  1  pixel enable; all state advances only when ce=1 (tie high for 1 pixel/clk)
- pix_in  in  3*COLOR_W  {r,g,b} from upstream, valid PIPE_DELAY enabled cycles after the matching x/y
- x  out  CNT_W  horizontal count, 0..H_TOTAL-1
- y  out  CNT_W  vertical count, 0..V_TOTAL-1
- coord_active  out  1  x<H_ACTIVE && y<V_ACTIVE (undelayed)
- hs  out  1  delayed horizontal sync, polarity per HS_POL
- vs  out  1  delayed vertical sync, polarity per VS_POL
- de  out  1  delayed data enable (video active)
- sof  out  1  delayed one-enabled-cycle start-of-frame pulse
- red, green, blue  out  COLOR_W each  de ? pix_in fields : 0
- frame_cnt  out  FRAME_W  completed-frame count, wraps

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined analogously.
- Line order: active, front porch, sync, back porch. x=0 is the first visible pixel.
- Horizontal counter: on rst, x=0. On ce, x increments. At x=H_TOTAL-1 it wraps to 0 and asserts the line-end condition.
- Vertical counter: on ce with line-end, y increments. At y=V_TOTAL-1 it wraps to 0 and frame_cnt increments (modulo 2^FRAME_W).
- With ce=0, every register holds, including the pipeline.
- Raw sync decode: raw_hs is asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. raw_vs is asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, over whole lines.
- raw_de = coord_active.
- raw_sof = (x==0 && y==0).
- Delay pipeline: shift register PIPE_DELAY deep carrying {raw_hs, raw_vs, raw_de, raw_sof}, advancing on ce.
- Pipeline outputs: hs/vs/de/sof are the last stage. Polarity is applied at the output: hs = raw_hs_d ? HS_POL : ~HS_POL.
- PIPE_DELAY=0: outputs are combinational from the counters.
- Colour outputs are combinational from pix_in and de. Blanking forces 0.
- Reset values: x=0, y=0, frame_cnt=0, and all pipeline stages cleared to non-asserted.
- First clock after rst release: hs=~HS_POL, vs=~VS_POL, de=0, sof=0, colour=0, coord_active=1.
- The first sof emerges after PIPE_DELAY enabled cycles; with PIPE_DELAY=0 it is present immediately.
- Reset mid-frame: counters and pipeline clear on the same edge. No partial sync pulse survives into the next frame, and frame_cnt restarts at 0.
- Simultaneous line-end and frame-end: x and y both wrap on the same edge, and frame_cnt increments on that same edge.
- ce held low across a wrap: no increment occurs until the next ce.

Decomposition:
- Shared package video_timing_pkg holds:
  - localparam totals H_TOTAL and V_TOTAL, as functions of the parameters;
  - a 640x480@60 preset constant set;
  - a 1280x720@60 preset constant set;
  - the sync-flag struct/bit ordering {hs,vs,de,sof} used by the delay line.
- One sub-module, timing_delay_line (parameters WIDTH, DEPTH, with ce). It is reused later to align HDMI audio and overlay signals.

Test Plan:
- Reset and free-run, defaults, ce=1, PIPE_DELAY=0 -> first hs assertion at x=656 lasting 96 clocks; line period 800 clocks; vs asserted for lines 490..491; frame period 420000 clocks; frame_cnt=1 after the first wrap.
- Small config (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, PIPE_DELAY=2) -> de high exactly 8 enabled cycles per active line, lagging coord_active by 2 cycles; 32 de cycles per frame.
- Same config with pix_in driven as {x,y}-derived values delayed 2 cycles by the bench -> red/green/blue equal the value for each (x,y) when de=1 and 0 otherwise; no off-by-one at x=0 or x=7.
- ce toggled 1,0,0,1 pattern -> counters and hs/vs/de hold while ce=0; the pixel period stretches by the enable ratio; no glitch on outputs.
- Polarity: HS_POL=0, VS_POL=0 -> hs idle 1 and low only in the sync window; vs likewise; reset values are 1.
- rst asserted for one clock at x=5, y=2 mid-frame -> next cycle x=0, y=0, frame_cnt=0, de=0; sof emerges 2 enabled cycles later.
